// File: rtl/fwrisc_regfile_dumper.sv
// fwrisc_regfile_dumper: walks a register range via the regfile read port and streams each word (optional index header, then little-endian bytes) over a valid/ready byte channel
module fwrisc_regfile_dumper #(
  parameter int ADDR_W   = 6,
  parameter bit EMIT_HDR = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_raddr,
  input  logic [31:0]       rd_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  typedef enum logic [2:0] {IDLE, REQ, CAPT, HDR, DATA, FIN} state_t;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  state_t          state;
  logic [ADDR_W:0] idx, last, idx_nxt;
  logic [31:0]     word;
  logic [1:0]      bsel, bnx;
  assign idx_nxt = idx + ONE;
  assign bnx     = bsel + 2'd1;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      last     <= '0;
      word     <= '0;
      bsel     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_req   <= 1'b0;
      rd_raddr <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx  <= {1'b0, first_idx};
          last <= {1'b0, last_idx};
          busy <= 1'b1;
          if (first_idx > last_idx) state <= FIN;
          else begin
            state    <= REQ;
            rd_req   <= 1'b1;
            rd_raddr <= first_idx;
          end
        end
        REQ: state <= CAPT;
        CAPT: begin
          word     <= rd_rdata;
          rd_req   <= 1'b0;
          tx_valid <= 1'b1;
          bsel     <= 2'd0;
          if (EMIT_HDR) begin
            tx_data <= 8'(idx[ADDR_W-1:0]);
            state   <= HDR;
          end else begin
            tx_data <= rd_rdata[7:0];
            state   <= DATA;
          end
        end
        HDR: if (tx_ready) begin
          tx_data <= word[7:0];
          state   <= DATA;
        end
        DATA: if (tx_ready) begin
          if (bsel != 2'd3) begin
            bsel    <= bnx;
            tx_data <= word[{bnx, 3'b000} +: 8];
          end else begin
            tx_valid <= 1'b0;
            if (idx == last) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              idx      <= idx_nxt;
              rd_req   <= 1'b1;
              rd_raddr <= idx_nxt[ADDR_W-1:0];
              state    <= REQ;
            end
          end
        end
        FIN: if (done) begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end else done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fwrisc_regfile_dumper.sv
// tb_fwrisc_regfile_dumper: scoreboard bench for the register file dumper
module tb_fwrisc_regfile_dumper;
  localparam int AW  = 6;
  localparam bit HDR = 1'b1;
  logic          clock = 1'b0, reset = 1'b0, start = 1'b0, tx_ready = 1'b0;
  logic [AW-1:0] first_idx = '0, last_idx = '0, rd_raddr;
  logic          busy, done, rd_req, tx_valid;
  logic [7:0]    tx_data;
  logic [31:0]   rd_rdata = '0;
  logic [31:0]   rf [64];
  logic [7:0]    sb [$];
  int            n_checks = 0, n_fail = 0;
  int            done_cyc, n_done, n_rd, n_valid;
  bit            saw_zero;
  always #5 clock = ~clock;
  always @(posedge clock) rd_rdata <= (rd_raddr == 0) ? 32'h0 : rf[rd_raddr];
  fwrisc_regfile_dumper #(.ADDR_W(AW), .EMIT_HDR(HDR)) dut (
    .clock(clock), .reset(reset), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_raddr(rd_raddr), .rd_rdata(rd_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );
  task automatic push_range(input int f, input int l);
    for (int i = f; i <= l; i++) begin
      logic [31:0] w;
      w = (i == 0) ? 32'h0 : rf[i];
      if (HDR) sb.push_back(8'(i));
      for (int b = 0; b < 4; b++) sb.push_back(w[8*b +: 8]);
    end
  endtask
  task automatic run_dump(input int f, input int l, input int pct);
    logic [7:0] exp_b, prev_data;
    bit prev_stall, fin;
    prev_stall = 0; fin = 0; prev_data = '0;
    done_cyc = -1; n_done = 0; n_rd = 0; n_valid = 0; saw_zero = 0;
    push_range(f, l);
    @(negedge clock);
    start = 1'b1; first_idx = AW'(f); last_idx = AW'(l); tx_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (rd_req) begin
        n_rd++;
        if (rd_raddr == 0) saw_zero = 1;
      end
      if (tx_valid) n_valid++;
      if (prev_stall) begin
        n_checks++;
        if ({tx_valid, tx_data} !== {1'b1, prev_data}) begin
          n_fail++;
          $display("FAIL hold: valid/data=%b/%h required 1/%h", tx_valid, tx_data, prev_data);
        end
      end
      tx_ready = ($urandom_range(99) < pct);
      if (tx_valid && tx_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_byte: got %h, none expected", tx_data);
        end else begin
          exp_b = sb.pop_front();
          if (tx_data !== exp_b) begin
            n_fail++;
            $display("FAIL byte: got %h required %h", tx_data, exp_b);
          end
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (!busy && done_cyc > 0) fin = 1;
      @(negedge clock);
    end
    tx_ready = 1'b0;
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL timeout: dump %0d..%0d never finished", f, l);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_bytes: %0d left, required 0", sb.size());
    end
    sb.delete();
  endtask
  task automatic test_reset;
    #12;
    n_checks++;
    if ({busy, done, rd_req, tx_valid, rd_raddr, tx_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b rd_req=%b tx_valid=%b raddr=%h data=%h required all 0",
               busy, done, rd_req, tx_valid, rd_raddr, tx_data);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask
  task automatic test_single;
    rf[5] = 32'hA1B2C3D4;
    run_dump(5, 5, 100);
    n_checks++;
    if (done_cyc !== 8) begin n_fail++; $display("FAIL single_done_cycle: %0d required 8", done_cyc); end
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL single_done_count: %0d required 1", n_done); end
  endtask
  task automatic test_multi;
    rf[0] = 32'hDEADBEEF; rf[1] = 32'h1; rf[2] = 32'hFFFFFFFF;
    run_dump(0, 2, 100);
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL multi_done_count: %0d required 1", n_done); end
    n_checks++;
    if (done_cyc !== 22) begin n_fail++; $display("FAIL multi_done_cycle: %0d required 22", done_cyc); end
  endtask
  task automatic test_random_ready;
    run_dump(0, 2, 30);
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL random_done_count: %0d required 1", n_done); end
  endtask
  task automatic test_empty;
    run_dump(10, 3, 100);
    n_checks++;
    if (done_cyc !== 2) begin n_fail++; $display("FAIL empty_done_cycle: %0d required 2", done_cyc); end
    n_checks++;
    if (n_rd !== 0 || n_valid !== 0) begin
      n_fail++;
      $display("FAIL empty_activity: rd_req cycles=%0d tx_valid cycles=%0d required 0/0", n_rd, n_valid);
    end
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL empty_done_count: %0d required 1", n_done); end
  endtask
  task automatic test_top_range;
    rf[62] = 32'h0BADF00D; rf[63] = 32'h76543210;
    run_dump(62, 63, 100);
    n_checks++;
    if (saw_zero !== 1'b0) begin n_fail++; $display("FAIL no_wrap: index 0 read, required none"); end
    n_checks++;
    if (done_cyc !== 15) begin n_fail++; $display("FAIL top_done_cycle: %0d required 15", done_cyc); end
    n_checks++;
    if (n_rd !== 4) begin n_fail++; $display("FAIL top_rd_cycles: %0d required 4", n_rd); end
  endtask
  task automatic test_reset_abort;
    int cnt, guard;
    bit sawd;
    cnt = 0; guard = 0; sawd = 0;
    for (int i = 1; i < 8; i++) rf[i] = $urandom;
    @(negedge clock);
    start = 1'b1; first_idx = 0; last_idx = 7;
    @(negedge clock);
    start = 1'b0; tx_ready = 1'b1;
    while (cnt < 3 && guard < 100) begin
      if (tx_valid) cnt++;
      guard++;
      @(negedge clock);
    end
    n_checks++;
    if (cnt !== 3 || busy !== 1'b1 || tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reach_b2: handshakes=%0d busy=%b valid=%b required 3/1/1", cnt, busy, tx_valid);
    end
    tx_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, rd_req, tx_valid, rd_raddr, tx_data} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b rd_req=%b tx_valid=%b raddr=%h data=%h required all 0",
               busy, done, rd_req, tx_valid, rd_raddr, tx_data);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done || busy || tx_valid) sawd = 1;
      @(negedge clock);
    end
    n_checks++;
    if (sawd !== 1'b0) begin n_fail++; $display("FAIL post_abort_idle: activity seen, required none"); end
    rf[1] = 32'h5A0FC3E1;
    run_dump(1, 1, 100);
    n_checks++;
    if (n_done !== 1 || done_cyc !== 8) begin
      n_fail++;
      $display("FAIL restart: done count=%0d cycle=%0d required 1/8", n_done, done_cyc);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rf[i] = $urandom;
    test_reset;
    test_single;
    test_multi;
    test_random_ready;
    test_empty;
    test_top_range;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
